// File: rtl/fm_mod.sv
// FM modulator: pops audio samples, integrates them into a wrapping phase
// accumulator and emits cos/sin through a quarter-wave sine table.
module fm_mod #(
    parameter int DATA_WIDTH = 32,
    parameter int QUANT      = 10,
    parameter int GAIN       = 1,
    parameter int PHASE_BITS = 16,
    parameter int LUT_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] audio_in,
    input  logic                  audio_empty,
    output logic                  audio_rd_en,
    output logic [DATA_WIDTH-1:0] i_out,
    output logic [DATA_WIDTH-1:0] q_out,
    input  logic                  full_i,
    input  logic                  full_q,
    output logic                  wr_en_iq
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int OFF_BITS   = LUT_BITS - 2;
    localparam logic [LUT_BITS-1:0] QTR_TURN = LUT_BITS'(1 << OFF_BITS);
    localparam logic [OFF_BITS:0]   QTR_IDX  = {1'b1, {OFF_BITS{1'b0}}};
    localparam logic signed [PROD_WIDTH-1:0] GAIN_EXT = PROD_WIDTH'(GAIN);

    // round(sin(2*pi*k/256) * 1024) for k = 0..64; sized for LUT_BITS=8, QUANT=10
    localparam logic [QUANT:0] SIN_TAB [0:(1 << OFF_BITS)] = '{
        11'd0,    11'd25,   11'd50,   11'd75,   11'd100,  11'd125,  11'd150,  11'd175,
        11'd200,  11'd224,  11'd249,  11'd273,  11'd297,  11'd321,  11'd345,  11'd369,
        11'd392,  11'd415,  11'd438,  11'd460,  11'd483,  11'd505,  11'd526,  11'd548,
        11'd569,  11'd590,  11'd610,  11'd630,  11'd650,  11'd669,  11'd688,  11'd706,
        11'd724,  11'd742,  11'd759,  11'd775,  11'd792,  11'd807,  11'd822,  11'd837,
        11'd851,  11'd865,  11'd878,  11'd891,  11'd903,  11'd915,  11'd926,  11'd936,
        11'd946,  11'd955,  11'd964,  11'd972,  11'd980,  11'd987,  11'd993,  11'd999,
        11'd1004, 11'd1009, 11'd1013, 11'd1016, 11'd1019, 11'd1021, 11'd1023, 11'd1024,
        11'd1024
    };

    typedef enum logic [2:0] {
        S_READ,
        S_MULT,
        S_ACC,
        S_LUT,
        S_WRITE
    } state_t;

    state_t                         state_q, state_d;
    logic [DATA_WIDTH-1:0]          audio_q, audio_d;
    logic signed [PROD_WIDTH-1:0]   prod_q, prod_d;
    logic [PHASE_BITS-1:0]          phase_q, phase_d;
    logic [DATA_WIDTH-1:0]          i_q, i_d;
    logic [DATA_WIDTH-1:0]          q_q, q_d;

    logic [LUT_BITS-1:0]            idx;
    logic signed [PROD_WIDTH-1:0]   audio_ext;

    // Odd quadrants mirror the table, the upper half of the turn negates it.
    function automatic logic signed [QUANT+1:0] sin_lut(input logic [LUT_BITS-1:0] pos);
        logic [OFF_BITS:0]       sel;
        logic signed [QUANT+1:0] mag;
        sel = pos[LUT_BITS-2] ? (QTR_IDX - {1'b0, pos[OFF_BITS-1:0]})
                              : {1'b0, pos[OFF_BITS-1:0]};
        mag = $signed({1'b0, SIN_TAB[sel]});
        return pos[LUT_BITS-1] ? -mag : mag;
    endfunction

    assign idx         = phase_q[PHASE_BITS-1 -: LUT_BITS];
    assign audio_ext   = {{DATA_WIDTH{audio_q[DATA_WIDTH-1]}}, audio_q};
    assign audio_rd_en = reset && (state_q == S_READ) && !audio_empty;
    assign wr_en_iq    = (state_q == S_WRITE) && !full_i && !full_q;
    assign i_out       = i_q;
    assign q_out       = q_q;

    always_comb begin
        state_d = state_q;
        audio_d = audio_q;
        prod_d  = prod_q;
        phase_d = phase_q;
        i_d     = i_q;
        q_d     = q_q;
        case (state_q)
            S_READ: begin
                if (audio_rd_en) begin
                    audio_d = audio_in;
                    state_d = S_MULT;
                end
            end
            S_MULT: begin
                prod_d  = audio_ext * GAIN_EXT;
                state_d = S_ACC;
            end
            S_ACC: begin
                phase_d = phase_q + PHASE_BITS'(prod_q >>> QUANT);
                state_d = S_LUT;
            end
            S_LUT: begin
                q_d     = DATA_WIDTH'(sin_lut(idx));
                i_d     = DATA_WIDTH'(sin_lut(idx + QTR_TURN));
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (wr_en_iq) begin
                    state_d = S_READ;
                end
            end
            default: state_d = S_READ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_READ;
            audio_q <= '0;
            prod_q  <= '0;
            phase_q <= '0;
            i_q     <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            audio_q <= audio_d;
            prod_q  <= prod_d;
            phase_q <= phase_d;
            i_q     <= i_d;
            q_q     <= q_d;
        end
    end

endmodule
